serializador_param: RTL and testbench

//  Parametrised parallel-to-serial converter for the PHY transmit path. It

---
 rtl/serializador_param.sv | 107 ++++++++++
 tb/tb_serializador_param.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializador_param.sv
// Parallel-to-serial word converter for the PHY transmit path. It sends comma training
// after reset, then user words taken through a one-deep valid/ready buffer.
//
// state | meaning
// TRAIN | link training: only IDLE_WORD is sent; commas are counted at each load
// RUN   | user data from the holding buffer, or IDLE_WORD when the buffer is empty
module serializador_param #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] IDLE_WORD   = 8'hBC,
   parameter int               SYNC_COMMAS = 4,
   parameter bit               MSB_FIRST   = 1'b1
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic             data_out,
   output logic             word_start,
   output logic             comma_out
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(SYNC_COMMAS + 1);

   typedef enum logic {TRAIN, RUN} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    comma_cnt, comma_cnt_n;
   logic [BW-1:0]    bit_cnt, bit_cnt_n;
   logic [WIDTH-1:0] buf_word;
   logic             buf_full, buf_full_n;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] load_word;
   logic             load_idle;
   logic             load;
   logic             xfer;
   logic             ready_n;

   always_comb begin
      load        = (bit_cnt == '0);
      xfer        = valid_in & ready_out;
      state_n     = state;
      comma_cnt_n = comma_cnt;
      load_word   = IDLE_WORD;
      load_idle   = 1'b1;
      buf_full_n  = buf_full;
      bit_cnt_n   = (bit_cnt == BW'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
      if (xfer)
         buf_full_n = 1'b1;
      if (load) begin
         case (state)
            TRAIN: begin
               // The switch happens on the load after the last training comma,
               // so that slot is still a comma and ready rises right after it.
               if (comma_cnt == CW'(SYNC_COMMAS))
                  state_n = RUN;
               else
                  comma_cnt_n = comma_cnt + 1'b1;
            end
            RUN: begin
               if (buf_full) begin
                  load_word  = buf_word;
                  load_idle  = 1'b0;
                  buf_full_n = 1'b0;
               end
            end
            default: state_n = TRAIN;
         endcase
      end
      ready_n = (state_n == RUN) & ~buf_full_n;
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state      <= TRAIN;
         comma_cnt  <= '0;
         bit_cnt    <= '0;
         buf_word   <= '0;
         buf_full   <= 1'b0;
         shift_reg  <= '0;
         ready_out  <= 1'b0;
         data_out   <= 1'b0;
         word_start <= 1'b0;
         comma_out  <= 1'b0;
      end else begin
         state     <= state_n;
         comma_cnt <= comma_cnt_n;
         bit_cnt   <= bit_cnt_n;
         buf_full  <= buf_full_n;
         ready_out <= ready_n;
         if (xfer)
            buf_word <= data_in;
         if (load) begin
            data_out   <= MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
            shift_reg  <= MSB_FIRST ? (load_word << 1) : (load_word >> 1);
            word_start <= 1'b1;
            comma_out  <= load_idle;
         end else begin
            data_out   <= MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
            shift_reg  <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
            word_start <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serializador_param.sv
// Directed bench for serializador_param: an 8-bit MSB-first instance and a
// 10-bit LSB-first instance driven from the same bit clock.
module tb_serializador_param;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b1;
   logic [7:0] data_in = '0;
   logic       valid_in = 1'b0;
   logic       ready_out, data_out, word_start, comma_out;

   logic       reset2 = 1'b1;
   logic [9:0] data2  = '0;
   logic       valid2 = 1'b0;
   logic       ready2, dout2, ws2, comma2;

   int errors = 0;
   int checks = 0;

   always #5 clk_32f = ~clk_32f;

   serializador_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .SYNC_COMMAS(4), .MSB_FIRST(1'b1)) dut (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .data_out(data_out), .word_start(word_start), .comma_out(comma_out));

   serializador_param #(.WIDTH(10), .IDLE_WORD(10'h17C), .SYNC_COMMAS(4), .MSB_FIRST(1'b0)) dut2 (
      .clk_32f(clk_32f), .reset(reset2), .data_in(data2), .valid_in(valid2),
      .ready_out(ready2), .data_out(dout2), .word_start(ws2), .comma_out(comma2));

   task automatic tick;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (ready_out) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic wait_data_slot(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (word_start && !comma_out) ok = 1'b1;
         else tick();
      end
   endtask

   // Current sample must be the first bit of a slot; leaves the bench on the last bit.
   task automatic capture8(output logic [7:0] bits, output int ncomma);
      bits = '0;
      ncomma = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         bits = {bits[6:0], data_out};
         ncomma += int'(comma_out);
      end
   endtask

   task automatic send8(input logic [7:0] w);
      bit ok;
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL send_ready: ready_out=%b required 1 within bound", ready_out); end
      data_in  = w;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] idle;
      idle = 8'hBC;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({data_out, word_start, comma_out, ready_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: dout/ws/comma/ready=%b%b%b%b required 0000",
                     data_out, word_start, comma_out, ready_out);
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         checks++;
         if (data_out !== idle[7 - (k % 8)]) begin
            errors++; $display("FAIL train_data k=%0d: data_out=%b required %b", k, data_out, idle[7 - (k % 8)]);
         end
         checks++;
         if (word_start !== (k % 8 == 0)) begin
            errors++; $display("FAIL train_ws k=%0d: word_start=%b required %b", k, word_start, (k % 8 == 0));
         end
         checks++;
         if (comma_out !== 1'b1) begin
            errors++; $display("FAIL train_comma k=%0d: comma_out=%b required 1", k, comma_out);
         end
         checks++;
         if (ready_out !== (k >= 32)) begin
            errors++; $display("FAIL train_ready k=%0d: ready_out=%b required %b", k, ready_out, (k >= 32));
         end
      end
   endtask

   task automatic test_single_word;
      bit ok;
      logic [7:0] bits;
      int nc;
      send8(8'hA5);
      wait_data_slot(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_slot: no data slot seen within bound"); end
      capture8(bits, nc);
      checks++;
      if (bits !== 8'hA5) begin errors++; $display("FAIL single_bits: got %b required 10100101", bits); end
      checks++;
      if (nc != 0) begin errors++; $display("FAIL single_comma: comma bits=%0d required 0", nc); end
      tick();
      checks++;
      if ({word_start, comma_out, data_out} !== 3'b111) begin
         errors++; $display("FAIL single_resume: ws/comma/dout=%b%b%b required 111", word_start, comma_out, data_out);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] words [3];
      logic       dv [64];
      logic       wv [64];
      logic       cv [64];
      bit ok;
      bit xfer;
      int nx, first;
      logic [23:0] stream;
      words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_ready: ready_out never rose"); end
      nx = 0;
      data_in = words[0];
      valid_in = 1'b1;
      for (int t = 0; t < 64; t++) begin
         xfer = valid_in && ready_out;
         tick();
         if (xfer) begin
            nx++;
            if (nx < 3) data_in = words[nx];
            else valid_in = 1'b0;
         end
         dv[t] = data_out; wv[t] = word_start; cv[t] = comma_out;
      end
      valid_in = 1'b0;
      checks++;
      if (nx != 3) begin errors++; $display("FAIL b2b_count: transfers=%0d required 3", nx); end
      first = -1;
      for (int t = 0; t < 64; t++)
         if (first < 0 && wv[t] && !cv[t]) first = t;
      checks++;
      if (first < 0 || first > 39) begin
         errors++; $display("FAIL b2b_start: first data slot at %0d required 0..39", first);
      end else begin
         stream = '0;
         for (int i = 0; i < 24; i++) stream = {stream[22:0], dv[first + i]};
         checks++;
         if (stream !== 24'h00FF3C) begin
            errors++; $display("FAIL b2b_bits: got %h required 00ff3c", stream);
         end
         for (int i = 0; i < 24; i++) begin
            checks++;
            if (cv[first + i] !== 1'b0 || wv[first + i] !== (i % 8 == 0)) begin
               errors++; $display("FAIL b2b_flags i=%0d: comma=%b ws=%b required 0 %b",
                                  i, cv[first + i], wv[first + i], (i % 8 == 0));
            end
         end
         checks++;
         if (cv[first + 24] !== 1'b1) begin
            errors++; $display("FAIL b2b_after: comma_out=%b required 1", cv[first + 24]);
         end
      end
   endtask

   task automatic test_reset_midword;
      bit ok;
      logic [3:0] head;
      logic [7:0] idle;
      idle = 8'hBC;
      send8(8'h5A);
      wait_data_slot(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midword_slot: no data slot seen within bound"); end
      checks++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL midword_ready: ready_out=%b required 1", ready_out); end
      head[3] = data_out;
      data_in = 8'h33;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      head[2] = data_out;
      tick(); head[1] = data_out;
      tick(); head[0] = data_out;
      checks++;
      if (head !== 4'b0101) begin errors++; $display("FAIL midword_head: got %b required 0101", head); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({data_out, word_start, comma_out, ready_out} !== 4'b0000) begin
         errors++; $display("FAIL midword_reset: dout/ws/comma/ready=%b%b%b%b required 0000",
                            data_out, word_start, comma_out, ready_out);
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         checks++;
         if (data_out !== idle[7 - (k % 8)] || comma_out !== 1'b1 || word_start !== (k % 8 == 0)) begin
            errors++; $display("FAIL retrain_slot k=%0d: dout=%b comma=%b ws=%b required %b 1 %b",
                               k, data_out, comma_out, word_start, idle[7 - (k % 8)], (k % 8 == 0));
         end
         checks++;
         if (ready_out !== (k >= 32)) begin
            errors++; $display("FAIL retrain_ready k=%0d: ready_out=%b required %b", k, ready_out, (k >= 32));
         end
      end
   endtask

   task automatic test_lsb_first;
      logic [9:0] idle_seq, bits;
      bit ok;
      int nc;
      idle_seq = 10'b0011111010;
      reset2 = 1'b1;
      tick(); tick();
      reset2 = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         checks++;
         if (dout2 !== idle_seq[9 - (k % 10)] || ws2 !== (k % 10 == 0)) begin
            errors++; $display("FAIL lsb_idle k=%0d: dout=%b ws=%b required %b %b",
                               k, dout2, ws2, idle_seq[9 - (k % 10)], (k % 10 == 0));
         end
         checks++;
         if (ready2 !== (k >= 40)) begin
            errors++; $display("FAIL lsb_ready k=%0d: ready=%b required %b", k, ready2, (k >= 40));
         end
      end
      data2 = 10'h001;
      valid2 = 1'b1;
      tick();
      valid2 = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (ws2 && !comma2) ok = 1'b1;
         else tick();
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL lsb_slot: no data slot seen within bound"); end
      bits = '0;
      nc = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         bits = {bits[8:0], dout2};
         nc += int'(comma2);
      end
      checks++;
      if (bits !== 10'b1000000000 || nc != 0) begin
         errors++; $display("FAIL lsb_data: got %b comma bits=%0d required 1000000000 0", bits, nc);
      end
   endtask

   task automatic test_comma_valued_data;
      bit ok;
      logic [7:0] bits;
      int nc;
      send8(8'hBC);
      wait_data_slot(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bcdata_slot: no data slot seen within bound"); end
      capture8(bits, nc);
      checks++;
      if (bits !== 8'hBC || nc != 0) begin
         errors++; $display("FAIL bcdata_bits: got %b comma bits=%0d required 10111100 0", bits, nc);
      end
   endtask

   task automatic test_random_stream;
      logic [7:0] sent [$];
      logic [7:0] got [$];
      logic [7:0] acc;
      bit in_slot, slot_comma, xfer;
      int nb;
      in_slot = 1'b0; slot_comma = 1'b1; nb = 0; acc = '0;
      for (int t = 0; t < 320; t++) begin
         if (!valid_in && t < 260 && $urandom_range(0, 1) == 1) begin
            valid_in = 1'b1;
            data_in  = 8'($urandom_range(0, 255));
         end
         xfer = valid_in && ready_out;
         tick();
         if (xfer) begin
            sent.push_back(data_in);
            valid_in = 1'b0;
         end
         if (word_start) begin
            in_slot = 1'b1; slot_comma = comma_out; nb = 0; acc = '0;
         end
         if (in_slot) begin
            acc = {acc[6:0], data_out};
            nb++;
            if (nb == 8) begin
               if (!slot_comma) got.push_back(acc);
               in_slot = 1'b0;
            end
         end
      end
      valid_in = 1'b0;
      checks++;
      if (sent.size() < 5) begin errors++; $display("FAIL rand_activity: transfers=%0d required >=5", sent.size()); end
      checks++;
      if (got.size() != sent.size()) begin
         errors++; $display("FAIL rand_count: decoded=%0d required %0d", got.size(), sent.size());
      end else begin
         for (int i = 0; i < sent.size(); i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
               errors++; $display("FAIL rand_word i=%0d: got %h required %h", i, got[i], sent[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_reset_midword();
      test_lsb_first();
      test_comma_valued_data();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
